// File: rtl/copperv_pkg.sv
// Shared types for the copperv core. ctrl_state_e carries StHalted only when
// COPPERV_HALT_EN is defined.
package copperv_pkg;

  typedef enum logic [3:0] {
    InstNone   = 4'd0,
    InstIntImm = 4'd1,
    InstIntReg = 4'd2,
    InstImm    = 4'd3,
    InstAuipc  = 4'd4,
    InstJal    = 4'd5,
    InstJalr   = 4'd6,
    InstBranch = 4'd7,
    InstLoad   = 4'd8,
    InstStore  = 4'd9,
    InstFence  = 4'd10
  } inst_type_e;

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
`ifdef COPPERV_HALT_EN
    StWb     = 3'd5,
    StHalted = 3'd6
`else
    StWb     = 3'd5
`endif
  } ctrl_state_e;

  typedef enum logic [2:0] {
    RdDinAlu     = 3'd0,
    RdDinImm     = 3'd1,
    RdDinMem     = 3'd2,
    RdDinPcPlus4 = 3'd3,
    RdDinPcImm   = 3'd4
  } rd_din_sel_e;

  typedef enum logic [1:0] {
    PcNextPlus4 = 2'd0,
    PcNextPcImm = 2'd1,
    PcNextAlu   = 2'd2
  } pc_next_sel_e;

endpackage

// File: rtl/ctrl_wb_decode.sv
// Writeback decode: maps the latched instruction class and branch compare to
// register-file write and next-PC selection. Outputs are idle outside WB.
module ctrl_wb_decode
  import copperv_pkg::*;
(
  input  logic         wb_active,
  input  inst_type_e   inst_type,
  input  logic         alu_cmp,
  output logic         rd_en,
  output rd_din_sel_e  rd_din_sel,
  output pc_next_sel_e pc_next_sel
);

  always_comb begin
    rd_en       = 1'b0;
    rd_din_sel  = RdDinAlu;
    pc_next_sel = PcNextPlus4;
    if (wb_active) begin
      unique case (inst_type)
        InstIntImm, InstIntReg: begin
          rd_en = 1'b1;
        end
        InstImm: begin
          rd_en      = 1'b1;
          rd_din_sel = RdDinImm;
        end
        InstAuipc: begin
          rd_en      = 1'b1;
          rd_din_sel = RdDinPcImm;
        end
        InstJal: begin
          rd_en       = 1'b1;
          rd_din_sel  = RdDinPcPlus4;
          pc_next_sel = PcNextPcImm;
        end
        InstJalr: begin
          rd_en       = 1'b1;
          rd_din_sel  = RdDinPcPlus4;
          pc_next_sel = PcNextAlu;
        end
        InstBranch: begin
          pc_next_sel = alu_cmp ? PcNextPcImm : PcNextPlus4;
        end
        InstLoad: begin
          rd_en      = 1'b1;
          rd_din_sel = RdDinMem;
        end
        default: begin
          // store, fence and unused encodings: no writeback, fall through
        end
      endcase
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control FSM for the copperv core, one instruction in flight.
// Defining COPPERV_HALT_EN adds the halt input, halted output and HALTED state.
module ctrl_sequencer
  import copperv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_valid,
  input  inst_type_e   inst_type,
  input  logic         alu_cmp,
  input  logic         data_valid,
`ifdef COPPERV_HALT_EN
  input  logic         halt,
  output logic         halted,
`endif
  output logic         inst_fetch,
  output logic         rs_en,
  output logic         alu_en,
  output logic         data_req,
  output logic         data_we,
  output logic         rd_en,
  output rd_din_sel_e  rd_din_sel,
  output logic         pc_en,
  output pc_next_sel_e pc_next_sel
);

  ctrl_state_e state_q, state_d;
  logic        entry_q;
  inst_type_e  inst_type_q;
  logic        alu_cmp_q;

  // entry_q marks the first cycle spent in the current state, so the bus
  // requests pulse once even while the state waits on a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StReset;
      entry_q     <= 1'b0;
      inst_type_q <= InstNone;
      alu_cmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
      if (state_q == StDecode) inst_type_q <= inst_type;
      if (state_q == StExec)   alu_cmp_q   <= alu_cmp;
    end
  end

  always_comb begin
    state_d    = state_q;
    inst_fetch = 1'b0;
    rs_en      = 1'b0;
    alu_en     = 1'b0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    pc_en      = 1'b0;
`ifdef COPPERV_HALT_EN
    halted     = 1'b0;
`endif
    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        inst_fetch = entry_q;
        if (inst_valid) state_d = StDecode;
      end
      StDecode: begin
        rs_en   = 1'b1;
        state_d = StExec;
      end
      StExec: begin
        alu_en  = 1'b1;
        state_d = (inst_type_q inside {InstLoad, InstStore}) ? StMem : StWb;
      end
      StMem: begin
        data_req = entry_q;
        data_we  = (inst_type_q == InstStore);
        if (data_valid) state_d = StWb;
      end
      StWb: begin
        pc_en   = 1'b1;
        state_d = StFetch;
`ifdef COPPERV_HALT_EN
        if (halt) state_d = StHalted;
`endif
      end
`ifdef COPPERV_HALT_EN
      StHalted: begin
        halted = 1'b1;
        if (!halt) state_d = StFetch;
      end
`endif
      default: state_d = StReset;
    endcase
  end

  ctrl_wb_decode u_wb_decode (
    .wb_active   (state_q == StWb),
    .inst_type   (inst_type_q),
    .alu_cmp     (alu_cmp_q),
    .rd_en       (rd_en),
    .rd_din_sel  (rd_din_sel),
    .pc_next_sel (pc_next_sel)
  );

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: walks every instruction class through the
// FSM with hand-derived per-cycle output vectors.
module tb_ctrl_sequencer;
  import copperv_pkg::*;

  logic         clk        = 1'b0;
  logic         rst        = 1'b1;
  logic         inst_valid = 1'b0;
  logic         alu_cmp    = 1'b0;
  logic         data_valid = 1'b0;
  inst_type_e   inst_type  = InstNone;
  logic         inst_fetch, rs_en, alu_en, data_req, data_we, rd_en, pc_en;
  rd_din_sel_e  rd_din_sel;
  pc_next_sel_e pc_next_sel;
`ifdef COPPERV_HALT_EN
  logic         halt = 1'b0;
  logic         halted;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .inst_valid  (inst_valid),
    .inst_type   (inst_type),
    .alu_cmp     (alu_cmp),
    .data_valid  (data_valid),
`ifdef COPPERV_HALT_EN
    .halt        (halt),
    .halted      (halted),
`endif
    .inst_fetch  (inst_fetch),
    .rs_en       (rs_en),
    .alu_en      (alu_en),
    .data_req    (data_req),
    .data_we     (data_we),
    .rd_en       (rd_en),
    .rd_din_sel  (rd_din_sel),
    .pc_en       (pc_en),
    .pc_next_sel (pc_next_sel)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // {inst_fetch, rs_en, alu_en, data_req, data_we, rd_en, pc_en, rd_din_sel, pc_next_sel}
  function automatic logic [11:0] ev(logic f, logic r, logic a, logic q, logic w, logic d,
                                     logic p, rd_din_sel_e s, pc_next_sel_e n);
    return {f, r, a, q, w, d, p, s, n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {inst_fetch, rs_en, alu_en, data_req, data_we, rd_en, pc_en, rd_din_sel, pc_next_sel};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Entered on the FETCH entry cycle; returns on the next FETCH entry cycle.
  task automatic do_inst(input string tag, input inst_type_e t, input logic cmp_exec,
                         input logic cmp_wb, input int iw, input int dw, input logic noise,
                         input logic exp_rd, input rd_din_sel_e es, input pc_next_sel_e en);
    logic mem, st;
    mem = (t == InstLoad) || (t == InstStore);
    st  = (t == InstStore);
    check({tag, " fetch"}, ev(1, 0, 0, 0, 0, 0, 0, RdDinAlu, PcNextPlus4));
    inst_type  = t;
    inst_valid = (iw == 0);
    data_valid = noise;
    for (int k = 1; k <= iw; k++) begin
      tick();
      check({tag, " fetch_wait"}, ev(0, 0, 0, 0, 0, 0, 0, RdDinAlu, PcNextPlus4));
      inst_valid = (k == iw);
    end
    tick();
    check({tag, " decode"}, ev(0, 1, 0, 0, 0, 0, 0, RdDinAlu, PcNextPlus4));
    inst_valid = noise;
    alu_cmp    = cmp_wb;
    tick();
    check({tag, " exec"}, ev(0, 0, 1, 0, 0, 0, 0, RdDinAlu, PcNextPlus4));
    alu_cmp    = cmp_exec;
    data_valid = 1'b0;
    if (mem) begin
      tick();
      alu_cmp = cmp_wb;
      check({tag, " mem_entry"}, ev(0, 0, 0, 1, st, 0, 0, RdDinAlu, PcNextPlus4));
      data_valid = (dw == 0);
      for (int k = 1; k <= dw; k++) begin
        tick();
        check({tag, " mem_wait"}, ev(0, 0, 0, 0, st, 0, 0, RdDinAlu, PcNextPlus4));
        data_valid = (k == dw);
      end
      tick();
      data_valid = 1'b0;
    end else begin
      tick();
      alu_cmp = cmp_wb;
    end
    check({tag, " wb"}, ev(0, 0, 0, 0, 0, exp_rd, 1, es, en));
    inst_valid = 1'b0;
    alu_cmp    = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    check("reset_held", ev(0, 0, 0, 0, 0, 0, 0, RdDinAlu, PcNextPlus4));
    rst = 1'b0;
    check("reset_cycle0", ev(0, 0, 0, 0, 0, 0, 0, RdDinAlu, PcNextPlus4));
    tick();

    do_inst("int_reg", InstIntReg, 1'b0, 1'b0, 1, 0, 1'b0, 1'b1, RdDinAlu, PcNextPlus4);
    do_inst("load", InstLoad, 1'b0, 1'b0, 0, 3, 1'b0, 1'b1, RdDinMem, PcNextPlus4);
    do_inst("store", InstStore, 1'b0, 1'b0, 0, 3, 1'b0, 1'b0, RdDinAlu, PcNextPlus4);
    do_inst("br_taken", InstBranch, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, RdDinAlu, PcNextPcImm);
    do_inst("br_not", InstBranch, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, RdDinAlu, PcNextPlus4);
    do_inst("jal", InstJal, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, RdDinPcPlus4, PcNextPcImm);
    do_inst("jalr", InstJalr, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, RdDinPcPlus4, PcNextAlu);
    do_inst("lui", InstImm, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, RdDinImm, PcNextPlus4);
    do_inst("auipc", InstAuipc, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, RdDinPcImm, PcNextPlus4);
    do_inst("fence", InstFence, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, RdDinAlu, PcNextPlus4);
    do_inst("unused_enc", inst_type_e'(4'd13), 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, RdDinAlu,
            PcNextPlus4);
    do_inst("int_imm", InstIntImm, 1'b0, 1'b0, 2, 0, 1'b0, 1'b1, RdDinAlu, PcNextPlus4);

    // Reset while MEM sees a data response: the response must be dropped.
    check("rstmem fetch", ev(1, 0, 0, 0, 0, 0, 0, RdDinAlu, PcNextPlus4));
    inst_type  = InstLoad;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
    tick();
    check("rstmem mem_entry", ev(0, 0, 0, 1, 0, 0, 0, RdDinAlu, PcNextPlus4));
    data_valid = 1'b1;
    rst        = 1'b1;
    tick();
    check("rstmem reset", ev(0, 0, 0, 0, 0, 0, 0, RdDinAlu, PcNextPlus4));
    rst        = 1'b0;
    data_valid = 1'b0;
    tick();

    do_inst("noisy", InstIntImm, 1'b0, 1'b0, 1, 0, 1'b1, 1'b1, RdDinAlu, PcNextPlus4);

`ifdef COPPERV_HALT_EN
    check("halt fetch", ev(1, 0, 0, 0, 0, 0, 0, RdDinAlu, PcNextPlus4));
    inst_type  = InstIntImm;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    halt       = 1'b1;
    tick();
    tick();
    check("halt wb", ev(0, 0, 0, 0, 0, 1, 1, RdDinAlu, PcNextPlus4));
    check_bit("halt wb_halted", halted, 1'b0);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("halted outputs", ev(0, 0, 0, 0, 0, 0, 0, RdDinAlu, PcNextPlus4));
      check_bit("halted flag", halted, 1'b1);
    end
    tick();
    halt = 1'b0;
    check_bit("halted last", halted, 1'b1);
    tick();
    check_bit("halt released", halted, 1'b0);
`endif

    check("final fetch", ev(1, 0, 0, 0, 0, 0, 0, RdDinAlu, PcNextPlus4));
    tick();
    check("final fetch_wait", ev(0, 0, 0, 0, 0, 0, 0, RdDinAlu, PcNextPlus4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
